// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: combinational instruction ROM port plus the IF/ID valid/ready handoff to decode.
interface instruction_fetch_if;
  logic [31:0] instr_addr;
  logic [31:0] instr_code;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  modport master (
    output instr_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  instr_code, id_ready
  );

  modport slave (
    input  instr_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output instr_code, id_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, captures ROM words into the IF/ID register, handles redirects.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets trap into a sticky FAULT state.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_fault,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, IDLE, FAULT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] plus4_reg, plus4_next;
  logic        valid_reg, valid_next;
  logic        advance;
  logic        redirect_bad;
  logic [31:0] target;

  assign advance = !valid_reg || bus.id_ready;
  assign target  = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_reg;

  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault_reg <= 1'b0;
    else if (state_next == FAULT)
      fault_reg <= 1'b1;
  end

  assign misalign_fault = fault_reg;
`else
  assign redirect_bad   = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    id_pc_next = id_pc_reg;
    plus4_next = plus4_reg;
    valid_next = valid_reg;

    // Decode taking the entry empties the register unless RUN refills it below.
    if (valid_reg && bus.id_ready) begin
      valid_next = 1'b0;
      instr_next = NOP_INSTR;
    end

    case (state_reg)
      BOOT: state_next = fetch_en ? RUN : IDLE;
      RUN: begin
        if (!fetch_en) begin
          state_next = IDLE;
        end else if (advance && !redirect_valid) begin
          instr_next = bus.instr_code;
          id_pc_next = pc_reg;
          plus4_next = pc_reg + 32'd4;
          valid_next = 1'b1;
          pc_next    = pc_reg + 32'd4;
        end
      end
      IDLE: begin
        if (fetch_en)
          state_next = RUN;
      end
      FAULT: begin
        valid_next = 1'b0;
        instr_next = NOP_INSTR;
      end
    endcase

    // A redirect overrides any capture; a same-cycle acceptance by decode still stands.
    if (redirect_valid && state_reg != FAULT) begin
      valid_next = 1'b0;
      instr_next = NOP_INSTR;
      if (redirect_bad)
        state_next = FAULT;
      else
        pc_next = target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      instr_reg <= NOP_INSTR;
      id_pc_reg <= 32'd0;
      plus4_reg <= 32'd0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      id_pc_reg <= id_pc_next;
      plus4_reg <= plus4_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.instr_addr  = pc_reg;
  assign bus.id_valid    = valid_reg;
  assign bus.id_instr    = instr_reg;
  assign bus.id_pc       = id_pc_reg;
  assign bus.id_pc_plus4 = plus4_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table for steady-state behaviour,
// hand sequences for asynchronous reset and boot-cycle corner cases.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        misalign_fault;
  int          total = 0;
  int          bad = 0;

  instruction_fetch_if bus();

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_fault (misalign_fault),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[23:0], 8'h37} ^ 32'hA500_0000;
  endfunction

  assign bus.instr_code = rom_word(bus.instr_addr);

  typedef struct packed {
    logic        en;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        chk_nop;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(input logic en, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic v, input logic [31:0] pc,
                              input logic [31:0] addr, input logic nop, input logic flt);
    vec_t r;
    r.en = en; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.exp_valid = v; r.exp_pc = pc; r.exp_addr = addr; r.chk_nop = nop; r.exp_fault = flt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, bus.id_valid}, 32'd0);
    check({tag, "_instr"}, bus.id_instr, NOP);
    check({tag, "_idpc"}, bus.id_pc, 32'd0);
    check({tag, "_plus4"}, bus.id_pc_plus4, 32'd0);
    check({tag, "_addr"}, bus.instr_addr, 32'd0);
    check({tag, "_fault"}, {31'd0, misalign_fault}, 32'd0);
  endtask

  initial begin
    // en rdy rv rpc | valid id_pc addr chk_nop fault
    vecs[0]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0);
    vecs[1]  = mk(1, 1, 0, 32'h0,        1, 32'h0,        32'h4,        0, 0);
    vecs[2]  = mk(1, 1, 0, 32'h0,        1, 32'h4,        32'h8,        0, 0);
    vecs[3]  = mk(1, 1, 0, 32'h0,        1, 32'h8,        32'hC,        0, 0);
    vecs[4]  = mk(1, 0, 0, 32'h0,        1, 32'h8,        32'hC,        0, 0);
    vecs[5]  = mk(1, 0, 0, 32'h0,        1, 32'h8,        32'hC,        0, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,        1, 32'h8,        32'hC,        0, 0);
    vecs[7]  = mk(1, 1, 0, 32'h0,        1, 32'hC,        32'h10,       0, 0);
    vecs[8]  = mk(1, 1, 1, 32'h20,       0, 32'h0,        32'h20,       1, 0);
    vecs[9]  = mk(1, 1, 0, 32'h0,        1, 32'h20,       32'h24,       0, 0);
    vecs[10] = mk(1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,       32'hFFFF_FFFC, 1, 0);
    vecs[11] = mk(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h0,       0, 0);
    vecs[12] = mk(1, 1, 0, 32'h0,        1, 32'h0,        32'h4,        0, 0);
    vecs[13] = mk(0, 0, 0, 32'h0,        1, 32'h0,        32'h4,        0, 0);
    vecs[14] = mk(0, 0, 0, 32'h0,        1, 32'h0,        32'h4,        0, 0);
    vecs[15] = mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h4,        0, 0);
    vecs[16] = mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h4,        0, 0);
    vecs[17] = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h4,        0, 0);
    vecs[18] = mk(1, 1, 0, 32'h0,        1, 32'h4,        32'h8,        0, 0);
    vecs[19] = mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h8,        0, 0);
    vecs[20] = mk(0, 1, 1, 32'h40,       0, 32'h0,        32'h40,       1, 0);
    vecs[21] = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h40,       0, 0);
    vecs[22] = mk(1, 1, 0, 32'h0,        1, 32'h40,       32'h44,       0, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    vecs[23] = mk(1, 1, 1, 32'h22,       0, 32'h0,        32'h44,       1, 1);
    vecs[24] = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h44,       1, 1);
    vecs[25] = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h44,       1, 1);
`else
    vecs[23] = mk(1, 1, 1, 32'h22,       0, 32'h0,        32'h20,       1, 0);
    vecs[24] = mk(1, 1, 0, 32'h0,        1, 32'h20,       32'h24,       0, 0);
    vecs[25] = mk(1, 1, 0, 32'h0,        1, 32'h24,       32'h28,       0, 0);
`endif

    // Reset held across clock edges
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    $display("txn reset: valid=%0b addr=%h instr=%h", bus.id_valid, bus.instr_addr, bus.id_instr);

    bus.id_ready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      fetch_en       = vecs[i].en;
      bus.id_ready   = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      if (i == 0) rst_n = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, bus.id_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_addr", i), bus.instr_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_fault", i), {31'd0, misalign_fault}, {31'd0, vecs[i].exp_fault});
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_idpc", i), bus.id_pc, vecs[i].exp_pc);
        check($sformatf("v%0d_plus4", i), bus.id_pc_plus4, vecs[i].exp_pc + 32'd4);
        check($sformatf("v%0d_instr", i), bus.id_instr, rom_word(vecs[i].exp_pc));
      end else if (vecs[i].chk_nop) begin
        check($sformatf("v%0d_nop", i), bus.id_instr, NOP);
      end
      $display("txn %0d: en=%0b rdy=%0b rv=%0b rpc=%h -> valid=%0b id_pc=%h addr=%h instr=%h fault=%0b",
               i, vecs[i].en, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, bus.id_valid,
               bus.id_pc, bus.instr_addr, bus.id_instr, misalign_fault);
    end

    // Asynchronous reset mid-stream: outputs return to reset values with no clock edge
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst1");
    $display("txn async reset: valid=%0b addr=%h", bus.id_valid, bus.instr_addr);

    // Redirect during the boot cycle is taken and BOOT still moves to RUN
    fetch_en       = 1'b1;
    bus.id_ready   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    rst_n          = 1'b1;
    @(posedge clk);
    #1;
    check("boot_redir_valid", {31'd0, bus.id_valid}, 32'd0);
    check("boot_redir_addr", bus.instr_addr, 32'h80);
    $display("txn boot redirect: valid=%0b addr=%h", bus.id_valid, bus.instr_addr);
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    check("boot_redir_v2", {31'd0, bus.id_valid}, 32'd1);
    check("boot_redir_idpc", bus.id_pc, 32'h80);
    check("boot_redir_instr", bus.id_instr, rom_word(32'h80));
    check("boot_redir_addr2", bus.instr_addr, 32'h84);
    $display("txn post boot redirect: valid=%0b id_pc=%h addr=%h", bus.id_valid, bus.id_pc, bus.instr_addr);

    // Boot with fetch disabled lands in IDLE and fetches nothing
    rst_n    = 1'b0;
    fetch_en = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("boot_idle%0d_valid", k), {31'd0, bus.id_valid}, 32'd0);
      check($sformatf("boot_idle%0d_addr", k), bus.instr_addr, 32'd0);
      $display("txn boot idle %0d: valid=%0b addr=%h", k, bus.id_valid, bus.instr_addr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
